// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 bus-cycle timing engine driven by a software GO edge.
// Ports: i_io_lcd control word in, o_lcd_status poll word out, LCD pad pins.
module lcd_ctrl #(
  parameter int T_AS   = 3,
  parameter int T_PW   = 12,
  parameter int T_H    = 2,
  parameter int T_EXEC = 2000,
  parameter int T_LONG = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic [31:0] o_lcd_status,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_data_oe,
  input  logic [7:0]  i_lcd_data
);

  localparam int M1 = (T_LONG > T_EXEC) ? T_LONG : T_EXEC;
  localparam int M2 = (T_PW > T_AS) ? T_PW : T_AS;
  localparam int M3 = (M1 > M2) ? M1 : M2;
  localparam int MAXT = (M3 > T_H) ? M3 : T_H;
  localparam int CW = $clog2(MAXT + 1);

  localparam logic [CW-1:0] AS_L = CW'(T_AS - 1);
  localparam logic [CW-1:0] PW_L = CW'(T_PW - 1);
  localparam logic [CW-1:0] H_L  = CW'(T_H - 1);
  localparam logic [CW-1:0] EX_L = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LG_L = CW'(T_LONG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          go_q;
  logic          rs_q;
  logic          rw_q;
  logic [7:0]    dat_q;
  logic          ovr_q;
  logic          busy_q;
  logic [7:0]    rd_q;
  logic          on_q;
  logic          en_q;
  logic          prs_q;
  logic          prw_q;
  logic [7:0]    pdat_q;
  logic          poe_q;

  logic go_edge;
  logic cnt_zero;
  logic is_long;
  logic unused_bits;

  assign go_edge  = i_io_lcd[10] & ~go_q;
  assign cnt_zero = (cnt_q == '0);
  // clear (0x01) and home (0x02/0x03) need the long execution wait
  assign is_long  = ~rs_q & (dat_q[7:2] == 6'd0) & (dat_q[1:0] != 2'd0);
  assign unused_bits = ^i_io_lcd[30:12];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      go_q <= 1'b1;
      on_q <= 1'b0;
    end else begin
      go_q <= i_io_lcd[10];
      on_q <= i_io_lcd[31];
    end
  end

  // edges outside IDLE are dropped; a drop beats a same-cycle clear
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ovr_q <= 1'b0;
    end else if (go_edge && state_q != S_IDLE) begin
      ovr_q <= 1'b1;
    end else if (i_io_lcd[11]) begin
      ovr_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      dat_q   <= 8'h00;
      busy_q  <= 1'b0;
      rd_q    <= 8'h00;
      en_q    <= 1'b0;
      prs_q   <= 1'b0;
      prw_q   <= 1'b1;
      pdat_q  <= 8'h00;
      poe_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go_edge) begin
            state_q <= S_SETUP;
            cnt_q   <= AS_L;
            rs_q    <= i_io_lcd[9];
            rw_q    <= i_io_lcd[8];
            dat_q   <= i_io_lcd[7:0];
            busy_q  <= 1'b1;
            prs_q   <= i_io_lcd[9];
            prw_q   <= i_io_lcd[8];
            pdat_q  <= i_io_lcd[7:0];
            poe_q   <= ~i_io_lcd[8];
          end
        end
        S_SETUP: begin
          if (cnt_zero) begin
            state_q <= S_PULSE;
            cnt_q   <= PW_L;
            en_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt_zero) begin
            state_q <= S_HOLD;
            cnt_q   <= H_L;
            en_q    <= 1'b0;
            if (rw_q) rd_q <= i_lcd_data;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            state_q <= S_EXEC;
            cnt_q   <= is_long ? LG_L : EX_L;
            prs_q   <= 1'b0;
            prw_q   <= 1'b1;
            pdat_q  <= 8'h00;
            poe_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_EXEC: begin
          if (cnt_zero) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          en_q    <= 1'b0;
          prs_q   <= 1'b0;
          prw_q   <= 1'b1;
          pdat_q  <= 8'h00;
          poe_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_lcd_status  = {22'd0, ovr_q, busy_q, rd_q};
  assign o_lcd_on      = on_q;
  assign o_lcd_en      = en_q;
  assign o_lcd_rs      = prs_q;
  assign o_lcd_rw      = prw_q;
  assign o_lcd_data    = pdat_q;
  assign o_lcd_data_oe = poe_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed stimulus for lcd_ctrl, checked every cycle against
// an elapsed-cycle model plus hand-computed literal expectations.
module tb_lcd_ctrl;

  localparam int T_AS   = 2;
  localparam int T_PW   = 4;
  localparam int T_H    = 1;
  localparam int T_EXEC = 10;
  localparam int T_LONG = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] io;
  logic [31:0] status;
  logic        lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_oe;
  logic [7:0]  lcd_dout;
  logic [7:0]  lcd_din;

  int checks = 0;
  int failures = 0;

  lcd_ctrl #(
    .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H),
    .T_EXEC(T_EXEC), .T_LONG(T_LONG)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_io_lcd(io),
    .o_lcd_status(status),
    .o_lcd_on(lcd_on),
    .o_lcd_en(lcd_en),
    .o_lcd_rs(lcd_rs),
    .o_lcd_rw(lcd_rw),
    .o_lcd_data(lcd_dout),
    .o_lcd_data_oe(lcd_oe),
    .i_lcd_data(lcd_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // model: a transaction is a count of elapsed busy cycles k out of tot
  bit       m_act;
  int       m_k, m_tot;
  bit       m_prev_go, m_ovr, m_on;
  bit       m_rs, m_rw;
  bit [7:0] m_dat, m_rd;

  always @(posedge clk) begin
    bit edge_s;
    if (rst) begin
      m_act = 0; m_k = 0; m_tot = 0;
      m_prev_go = 1; m_ovr = 0; m_on = 0; m_rd = 0;
      m_rs = 0; m_rw = 0; m_dat = 0;
    end else begin
      edge_s = io[10] && !m_prev_go;
      if (m_act) begin
        if (m_k == T_AS + T_PW - 1 && m_rw) m_rd = lcd_din;
        m_k++;
        if (m_k == m_tot) m_act = 0;
        if (edge_s) m_ovr = 1;
        else if (io[11]) m_ovr = 0;
      end else begin
        if (io[11]) m_ovr = 0;
        if (edge_s) begin
          m_act = 1; m_k = 0;
          m_rs = io[9]; m_rw = io[8]; m_dat = io[7:0];
          if (!m_rs && m_dat inside {8'h01, 8'h02, 8'h03})
            m_tot = T_AS + T_PW + T_H + T_LONG;
          else
            m_tot = T_AS + T_PW + T_H + T_EXEC;
        end
      end
      m_prev_go = io[10];
      m_on = io[31];
    end
  end

  int  busy_cur = 0, busy_last = 0;
  int  en_cur = 0, en_last = 0;
  bit  oe_any = 0;
  bit [7:0] en_data = 0;

  always @(posedge clk) begin
    bit drv, en_e;
    #1;
    en_e = m_act && m_k >= T_AS && m_k < T_AS + T_PW;
    drv  = m_act && m_k < T_AS + T_PW + T_H;
    chk("status", status, {22'd0, m_ovr, m_act, m_rd});
    chk("on", 32'(lcd_on), 32'(m_on));
    chk("en", 32'(lcd_en), 32'(en_e));
    chk("rs", 32'(lcd_rs), 32'(drv ? m_rs : 1'b0));
    chk("rw", 32'(lcd_rw), 32'(drv ? m_rw : 1'b1));
    chk("oe", 32'(lcd_oe), 32'(drv & ~m_rw));
    chk("data", 32'(lcd_dout), 32'(drv ? m_dat : 8'h00));
    if (status[8]) busy_cur++;
    else if (busy_cur > 0) begin busy_last = busy_cur; busy_cur = 0; end
    if (lcd_en) begin en_cur++; en_data = lcd_dout; end
    else if (en_cur > 0) begin en_last = en_cur; en_cur = 0; end
    if (lcd_oe) oe_any = 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_en(input logic v, input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      if (lcd_en === v) break;
      @(negedge clk);
    end
    if (i == lim) begin
      checks++; failures++;
      $display("FAIL wait_en timeout actual=%b required=%b", lcd_en, v);
    end
  endtask

  // GO pulse of one cycle, then wait for the transaction to drain
  task automatic go(input logic [31:0] w, input int drain);
    @(negedge clk);
    io = w | 32'h400;
    cycles(1);
    io = w & ~32'h400;
    cycles(drain);
  endtask

  initial begin
    rst = 1'b1;
    io = 32'h0000_0400;
    lcd_din = 8'h00;
    cycles(3);
    rst = 1'b0;
    cycles(5);
    chk("lit_noedge_busy", 32'(status[8]), 32'd0);
    chk("lit_noedge_run", 32'(busy_last), 32'd0);
    io = 32'h0;
    go(32'h0000_0000, 20);
    chk("lit_first_run", 32'(busy_last), 32'd17);

    go(32'h8000_0241, 20);
    chk("lit_A_run", 32'(busy_last), 32'd17);
    chk("lit_A_en", 32'(en_last), 32'd4);
    chk("lit_A_data", 32'(en_data), 32'h41);
    chk("lit_on", 32'(lcd_on), 32'd1);

    go(32'h0000_0001, 40);
    chk("lit_clear_run", 32'(busy_last), 32'd37);
    go(32'h0000_0038, 20);
    chk("lit_fset_run", 32'(busy_last), 32'd17);

    oe_any = 0;
    lcd_din = 8'h80;
    @(negedge clk);
    io = 32'h0000_0500;
    cycles(1);
    io = 32'h0000_0100;
    wait_en(1'b1, 10);
    wait_en(1'b0, 10);
    lcd_din = 8'h00;
    cycles(16);
    chk("lit_read_byte", 32'(status[7:0]), 32'h80);
    chk("lit_read_oe", 32'(oe_any), 32'd0);
    chk("lit_read_run", 32'(busy_last), 32'd17);

    @(negedge clk);
    io = 32'h0000_0438;
    cycles(1);
    io = 32'h0000_0038;
    cycles(9);
    io = 32'h0000_0438;
    cycles(1);
    io = 32'h0000_0038;
    cycles(12);
    chk("lit_ovr_set", 32'(status[9]), 32'd1);
    chk("lit_ovr_run", 32'(busy_last), 32'd17);
    io = 32'h0000_0800;
    cycles(1);
    io = 32'h0;
    cycles(1);
    chk("lit_ovr_clr", 32'(status[9]), 32'd0);

    @(negedge clk);
    io = 32'h0000_0438;
    cycles(1);
    io = 32'h0000_0038;
    cycles(9);
    io = 32'h0000_0C38;
    cycles(1);
    io = 32'h0000_0038;
    cycles(12);
    chk("lit_ovr_setwins", 32'(status[9]), 32'd1);

    io = 32'h0000_0800;
    cycles(1);
    io = 32'h0;
    @(negedge clk);
    io = 32'h0000_0438;
    cycles(1);
    io = 32'h0000_0038;
    cycles(16);
    io = 32'h0000_0438;
    cycles(1);
    io = 32'h0000_0038;
    cycles(2);
    chk("lit_lastcyc_drop", 32'(status[9]), 32'd1);
    chk("lit_lastcyc_idle", 32'(status[8]), 32'd0);

    io = 32'h0;
    @(negedge clk);
    io = 32'h0000_0438;
    cycles(1);
    io = 32'h0000_0038;
    cycles(17);
    io = 32'h0000_0438;
    cycles(1);
    chk("lit_nodead_busy", 32'(status[8]), 32'd1);
    io = 32'h0000_0038;
    cycles(18);

    lcd_din = 8'h5A;
    @(negedge clk);
    io = 32'h0000_0641;
    cycles(1);
    io = 32'h0000_0241;
    wait_en(1'b1, 10);
    #2;
    rst = 1'b1;
    #1;
    chk("lit_rst_en", 32'(lcd_en), 32'd0);
    chk("lit_rst_status", status, 32'd0);
    chk("lit_rst_rw", 32'(lcd_rw), 32'd1);
    @(negedge clk);
    io = 32'h0;
    cycles(2);
    rst = 1'b0;
    cycles(2);
    go(32'h0000_0241, 20);
    chk("lit_postrst_run", 32'(busy_last), 32'd17);
    chk("lit_postrst_byte", 32'(status[7:0]), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
